sipo_stream: RTL and testbench
==============================

Name: sipo_stream

Overview:
Parametrised serial-in/parallel-out packer, the successor to the fixed 8-bit SIPO. It packs SYM_W-bit symbols from the Viterbi traceback/decision stream into WORD_W-bit words, with selectable LSB- or MSB-first ordering. Input and output use valid/ready handshakes, and an OUT_DEPTH-entry output buffer sits between them. A flush request emits a partial word with a valid-beat count. It sits between the decoder's serial bit output and the byte-wide sink (UART/AXI-stream bridge).

Parameters:
WORD_W, 8, output word width in bits; must be a multiple of SYM_W.
SYM_W, 1, bits per input beat.
MSB_FIRST, 0, 0 = first beat lands in the LSBs (legacy SIPO ordering); 1 = first beat lands in the MSBs.
OUT_DEPTH, 2, output buffer entries; minimum 1.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_data  in  SYM_W  serial symbol
in_valid  in  1  in_data valid
in_ready  out  1  beat/flush can be accepted this cycle
flush  in  1  request to emit the current partial word
out_data  out  WORD_W  packed word (head of output buffer)
out_len  out  $clog2(BEATS+1)  valid beats in out_data (BEATS = WORD_W/SYM_W)
out_valid  out  1  buffer non-empty
out_ready  in  1  sink accepts head word

Behaviour:
- Reset: one clock and reset; reset is synchronous and active-high. When rst is sampled high, clear the accumulator, beat counter cnt, flush_pending, and buffer pointers. After reset: out_valid=0, out_data=0, out_len=0. in_ready=0 while rst is high and 1 in the first cycle after.
- A reset mid-word discards the partial word and every buffered word. No output is produced for them.
- Beat accept: in_valid && in_ready at a rising edge.
  - MSB_FIRST=0: beat k (k = cnt) is written to acc[k*SYM_W +: SYM_W].
  - MSB_FIRST=1: beat k is written to acc[WORD_W-1-k*SYM_W -: SYM_W].
  - cnt increments.
- Word complete: the accepted beat has cnt==BEATS-1.
  - Push {acc with this beat, out_len=BEATS} on the same edge.
  - Clear the accumulator to 0 and set cnt=0.
  - out_valid is high in the next cycle, giving 1-cycle latency from final beat to out_valid.
- in_ready = !(buffer full && (cnt==BEATS-1 || flush_pending)).
  - Non-final beats are always accepted unless in reset.
  - in_ready has no combinational path from out_ready.
- Flush:
  - A flush pulse sets flush_pending if it cannot be executed this cycle. flush_pending is a sticky request that is executed exactly once.
  - Execution occurs when the buffer is not full.
    - If cnt>0: push the partial word (unwritten bits =0) with out_len=cnt, then clear the accumulator and cnt.
    - If cnt==0: no push; just clear the request.
  - flush with an accepted beat in the same cycle: the beat is included first.
    - If that beat completes the word, only the full word is pushed and the flush is a no-op.
- Output: the head entry drives out_data/out_len. It pops on out_valid && out_ready.
  - Push and pop in the same cycle while full is allowed; the occupancy count is unchanged.
  - While out_valid=0, out_data and out_len hold their last values (0 after reset).
- Ordering: words leave in strict acceptance order. No word is dropped or duplicated under any backpressure pattern.
- Elaboration: a $fatal assertion fires if WORD_W % SYM_W != 0 or OUT_DEPTH < 1.

Decomposition:
- Package sipo_pkg holds:
  - function beats(WORD_W,SYM_W)
  - localparam helpers for the out_len and pointer widths
  - ORDER_LSB/ORDER_MSB constants
- Sub-module sync_fifo (parametrised width/depth, registered pointers, full/empty/count) implements the output buffer, width WORD_W+len width.
- The packer FSM and accumulator stay in sipo_stream. The states are IDLE (cnt==0), FILL (0<cnt<BEATS), and STALL (final beat or pending flush blocked by full buffer).

Test Plan:
- Default, out_ready=1: send bits 1,0,1,0,1,1,0,0 on consecutive cycles -> out_data=0x35, out_len=8, out_valid high for exactly 1 cycle, 1 cycle after the 8th beat.
- MSB_FIRST=1 with the same bit sequence -> out_data=0xAC, out_len=8. SYM_W=2 (LSB-first), beats 01,10,11,00 -> out_data=0x39, out_len=4.
- Flush: 3 beats 1,1,0 then flush -> out_data=0x03, out_len=3. Flush with cnt==0 -> no output. Flush in the same cycle as an 8th beat -> exactly one full word.
- Backpressure: OUT_DEPTH=2, out_ready=0, send 0x11,0x22,0x33 -> in_ready low at the 8th beat of 0x33 until out_ready=1. Then the output drains 0x11,0x22,0x33 in order with none lost.
- Reset mid-word: 4 beats, then rst for 1 cycle, then 8 one-bits -> single output 0xFF, len 8. Outputs equal 0 after reset.
- Random: 200 random words with random in_valid/out_ready gaps and occasional flushes, checked against a scoreboard model of the data, len and order -> zero mismatches.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and width helpers for the serial-in/parallel-out stream packer
// and its output buffer.
package sipo_pkg;

  localparam int ORDER_LSB = 0;
  localparam int ORDER_MSB = 1;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STALL
  } pack_state_e;

  function automatic int beats(input int word_w, input int sym_w);
    return word_w / sym_w;
  endfunction

  function automatic int len_width(input int word_w, input int sym_w);
    return $clog2(beats(word_w, sym_w) + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEFAULT_LEN_W = len_width(8, 1);
  localparam int DEFAULT_PTR_W = ptr_width(2);

endpackage

// File: rtl/sipo_stream_if.sv
// Symbol input and packed-word output handshakes of the stream packer.
interface sipo_stream_if
  import sipo_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int SYM_W  = 1
);

  localparam int LEN_W = len_width(WORD_W, SYM_W);

  logic [SYM_W-1:0]  in_data;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [WORD_W-1:0] out_data;
  logic [LEN_W-1:0]  out_len;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_len, out_valid
  );

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_len, out_valid
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy count; the head
// entry is presented combinationally on rdata.
module sync_fifo
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PTR_W = ptr_width(DEPTH),
  localparam int CNT_W = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem[rd_ptr_q];

  // A push into a full buffer is legal when the head leaves on the same edge.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sipo_stream.sv
// Packs SYM_W-bit symbols into WORD_W-bit words (LSB- or MSB-first) and
// queues them, with flush support for emitting partial words.
module sipo_stream
  import sipo_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int SYM_W     = 1,
  parameter int MSB_FIRST = ORDER_LSB,
  parameter int OUT_DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  sipo_stream_if.slave bus
);

  localparam int BEATS = beats(WORD_W, SYM_W);
  localparam int LEN_W = len_width(WORD_W, SYM_W);
  localparam int CNT_W = count_width(OUT_DEPTH);
  localparam int ENT_W = WORD_W + LEN_W;

  if ((WORD_W % SYM_W) != 0 || OUT_DEPTH < 1) begin : g_param_check
    $fatal(1, "sipo_stream: WORD_W must be a multiple of SYM_W and OUT_DEPTH must be >= 1");
  end

  pack_state_e       state_q, state_next;
  logic [LEN_W-1:0]  cnt_q, cnt_after, cnt_next, push_len;
  logic [WORD_W-1:0] acc_q, acc_beat, acc_next, push_data;
  logic              flush_pend_q, flush_pend_next;
  logic              in_ready_w, accept, final_beat, flush_req, flush_exec;
  logic              push, pop;
  logic              fifo_full, fifo_empty, full_next;
  logic [CNT_W-1:0]  fifo_count, occ_next;
  logic [ENT_W-1:0]  fifo_rdata;
  logic [WORD_W-1:0] head_data, hold_data_q;
  logic [LEN_W-1:0]  head_len, hold_len_q;

  // Accumulator image with the incoming beat dropped into its slot.
  always_comb begin
    acc_beat = acc_q;
    for (int b = 0; b < BEATS; b++) begin
      if (cnt_q == LEN_W'(b)) begin
        if (MSB_FIRST == ORDER_MSB) begin
          acc_beat[(BEATS - 1 - b) * SYM_W +: SYM_W] = bus.in_data;
        end else begin
          acc_beat[b * SYM_W +: SYM_W] = bus.in_data;
        end
      end
    end
  end

  always_comb begin
    accept     = bus.in_valid && in_ready_w;
    final_beat = accept && (cnt_q == LEN_W'(BEATS - 1));
    flush_req  = bus.flush || flush_pend_q;
    // A beat completing the word on the flush cycle makes the flush a no-op.
    flush_exec = flush_req && !final_beat && !fifo_full;
    cnt_after  = accept ? cnt_q + 1'b1 : cnt_q;
    push_data  = accept ? acc_beat : acc_q;
    push_len   = final_beat ? LEN_W'(BEATS) : cnt_after;
    push       = final_beat || (flush_exec && (cnt_after != '0));
    pop        = !fifo_empty && bus.out_ready;

    if (final_beat || flush_exec) begin
      cnt_next = '0;
      acc_next = '0;
    end else begin
      cnt_next = cnt_after;
      acc_next = push_data;
    end
    flush_pend_next = flush_req && !final_beat && fifo_full;

    occ_next = fifo_count;
    if (push && !pop) begin
      occ_next = fifo_count + 1'b1;
    end else if (!push && pop) begin
      occ_next = fifo_count - 1'b1;
    end
    full_next = (occ_next == CNT_W'(OUT_DEPTH));

    // Look ahead one cycle so in_ready comes straight from a register.
    if (full_next && ((cnt_next == LEN_W'(BEATS - 1)) || flush_pend_next)) begin
      state_next = STALL;
    end else if (cnt_next == '0) begin
      state_next = IDLE;
    end else begin
      state_next = FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_next;
      cnt_q        <= cnt_next;
      acc_q        <= acc_next;
      flush_pend_q <= flush_pend_next;
    end
  end

  assign in_ready_w   = !rst && (state_q != STALL);
  assign bus.in_ready = in_ready_w;

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({push_len, push_data}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {head_len, head_data} = fifo_rdata;

  // The last presented word stays on the bus once the buffer drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_data_q <= '0;
      hold_len_q  <= '0;
    end else if (!fifo_empty) begin
      hold_data_q <= head_data;
      hold_len_q  <= head_len;
    end
  end

  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_empty ? hold_data_q : head_data;
  assign bus.out_len   = fifo_empty ? hold_len_q : head_len;

endmodule

// File: tb/tb_sipo_stream.sv
// Bench for sipo_stream: a queue-based model of the default configuration is
// compared every cycle, plus literal checks on LSB/MSB/SYM_W=2 instances.
module tb_sipo_stream;
  import sipo_pkg::*;

  localparam int DEPTH = 2;
  localparam int BEATS = 8;

  typedef struct {
    logic [7:0] data;
    int         len;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sipo_stream_if #(.WORD_W(8), .SYM_W(1)) bus0 ();
  sipo_stream_if #(.WORD_W(8), .SYM_W(1)) bus1 ();
  sipo_stream_if #(.WORD_W(8), .SYM_W(2)) bus2 ();

  sipo_stream #(.WORD_W(8), .SYM_W(1), .MSB_FIRST(ORDER_LSB), .OUT_DEPTH(DEPTH)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0.slave)
  );
  sipo_stream #(.WORD_W(8), .SYM_W(1), .MSB_FIRST(ORDER_MSB), .OUT_DEPTH(DEPTH)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1.slave)
  );
  sipo_stream #(.WORD_W(8), .SYM_W(2), .MSB_FIRST(ORDER_LSB), .OUT_DEPTH(DEPTH)) dut2 (
    .clk (clk), .rst (rst), .bus (bus2.slave)
  );

  assign bus1.in_data   = bus0.in_data;
  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.flush     = bus0.flush;
  assign bus1.out_ready = bus0.out_ready;

  int         n_checks = 0;
  int         n_fail = 0;
  int         pops_total = 0;
  bit         chk_en = 1'b0;
  word_t      mq[$];
  bit         pb[$];
  bit         m_pend;
  logic [7:0] m_last_data;
  int         m_last_len;
  logic [7:0] popped[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic d, input logic f, output logic acc);
    bus0.in_valid = v;
    bus0.in_data  = d;
    bus0.flush    = f;
    acc = v && bus0.in_ready;
    @(posedge clk);
    #2;
  endtask

  task automatic sendBeat(input logic d);
    logic acc;
    int   n;
    n = 0;
    do begin
      applyStimulus(1'b1, d, 1'b0, acc);
      n++;
    end while (!acc && n < 50);
    checkOutput("beat_accepted", acc, 1);
  endtask

  task automatic sendWord(input logic [7:0] w);
    for (int i = 0; i < 8; i++) sendBeat(w[i]);
  endtask

  function automatic word_t pack_word();
    word_t w;
    w.data = '0;
    for (int i = 0; i < pb.size(); i++) w.data = w.data | (8'(pb[i]) << i);
    w.len = pb.size();
    return w;
  endfunction

  // Behavioural model: partial word as a bit list, output buffer as a queue.
  always @(posedge clk) begin : model
    bit was_full, ready, done;
    if (rst) begin
      mq.delete();
      pb.delete();
      m_pend = 1'b0;
      m_last_data = '0;
      m_last_len = 0;
    end else begin
      was_full = (mq.size() == DEPTH);
      ready = !(was_full && (pb.size() == BEATS - 1 || m_pend));
      done = 1'b0;
      if (mq.size() > 0) begin
        m_last_data = mq[0].data;
        m_last_len = mq[0].len;
        if (bus0.out_ready) void'(mq.pop_front());
      end
      if (bus0.in_valid && ready) begin
        pb.push_back(bus0.in_data[0]);
        if (pb.size() == BEATS) begin
          mq.push_back(pack_word());
          pb.delete();
          m_pend = 1'b0;
          done = 1'b1;
        end
      end
      if (!done && (bus0.flush || m_pend)) begin
        if (was_full) begin
          m_pend = 1'b1;
        end else begin
          if (pb.size() > 0) mq.push_back(pack_word());
          pb.delete();
          m_pend = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [7:0] ed;
    int         el;
    if (chk_en) begin
      ed = (mq.size() > 0) ? mq[0].data : m_last_data;
      el = (mq.size() > 0) ? mq[0].len : m_last_len;
      checkOutput("in_ready", bus0.in_ready,
                  !rst && !(mq.size() == DEPTH && (pb.size() == BEATS - 1 || m_pend)));
      checkOutput("out_valid", bus0.out_valid, mq.size() > 0);
      checkOutput("out_data", bus0.out_data, ed);
      checkOutput("out_len", bus0.out_len, el);
      if (!rst && bus0.out_valid && bus0.out_ready) begin
        popped.push_back(bus0.out_data);
        pops_total++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual still running, required $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic       acc;
    logic [7:0] seq;
    logic [1:0] s2 [4];
    int         mark;
    int         start;

    bus0.in_valid = 0; bus0.in_data = 0; bus0.flush = 0; bus0.out_ready = 1;
    bus2.in_valid = 0; bus2.in_data = 0; bus2.flush = 0; bus2.out_ready = 1;
    @(posedge clk); #2;
    chk_en = 1'b1;
    @(posedge clk); #2;
    checkOutput("reset_in_ready", bus0.in_ready, 0);
    checkOutput("reset_out_valid", bus0.out_valid, 0);
    checkOutput("reset_out_data", bus0.out_data, 0);
    checkOutput("reset_out_len", bus0.out_len, 0);
    rst = 1'b0;
    #1;
    checkOutput("ready_after_reset", bus0.in_ready, 1);

    // SYM_W=2, beats 01,10,11,00 LSB-first -> 0x39
    s2[0] = 2'b01; s2[1] = 2'b10; s2[2] = 2'b11; s2[3] = 2'b00;
    for (int i = 0; i < 4; i++) begin
      bus2.in_valid = 1'b1;
      bus2.in_data = s2[i];
      @(posedge clk); #2;
    end
    bus2.in_valid = 1'b0;
    checkOutput("sym2_valid", bus2.out_valid, 1);
    checkOutput("sym2_data", bus2.out_data, 8'h39);
    checkOutput("sym2_len", bus2.out_len, 4);

    // Bits 1,0,1,0,1,1,0,0 -> 0x35 LSB-first, 0xAC MSB-first
    seq = 8'b0011_0101;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, seq[i], 1'b0, acc);
    checkOutput("lsb_valid", bus0.out_valid, 1);
    checkOutput("lsb_data", bus0.out_data, 8'h35);
    checkOutput("lsb_len", bus0.out_len, 8);
    checkOutput("msb_valid", bus1.out_valid, 1);
    checkOutput("msb_data", bus1.out_data, 8'hAC);
    checkOutput("msb_len", bus1.out_len, 8);
    applyStimulus(1'b0, 1'b0, 1'b0, acc);
    checkOutput("lsb_valid_one_cycle", bus0.out_valid, 0);
    checkOutput("lsb_data_held", bus0.out_data, 8'h35);

    // Partial flush after beats 1,1,0
    applyStimulus(1'b1, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, 1'b0, 1'b1, acc);
    checkOutput("flush_valid", bus0.out_valid, 1);
    checkOutput("flush_data", bus0.out_data, 8'h03);
    checkOutput("flush_len", bus0.out_len, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, 1'b0, 1'b1, acc);
    checkOutput("flush_empty_no_word", bus0.out_valid, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, acc);
    checkOutput("flush_empty_still_none", bus0.out_valid, 0);

    // Flush on the final beat yields exactly one full word
    seq = 8'hA5;
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, seq[i], 1'b0, acc);
    applyStimulus(1'b1, seq[7], 1'b1, acc);
    checkOutput("flush_final_valid", bus0.out_valid, 1);
    checkOutput("flush_final_data", bus0.out_data, 8'hA5);
    checkOutput("flush_final_len", bus0.out_len, 8);
    applyStimulus(1'b0, 1'b0, 1'b0, acc);
    checkOutput("flush_final_single", bus0.out_valid, 0);

    // Backpressure: two words fill the buffer, final beat of the third stalls
    bus0.out_ready = 1'b0;
    sendWord(8'h11);
    sendWord(8'h22);
    seq = 8'h33;
    for (int i = 0; i < 7; i++) sendBeat(seq[i]);
    checkOutput("bp_ready_low", bus0.in_ready, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, seq[7], 1'b0, acc);
      checkOutput("bp_beat_blocked", acc, 0);
    end
    mark = popped.size();
    bus0.out_ready = 1'b1;
    sendBeat(seq[7]);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, acc);
    checkOutput("bp_drain_count", popped.size() - mark, 3);
    if (popped.size() - mark == 3) begin
      checkOutput("bp_drain_0", popped[mark], 8'h11);
      checkOutput("bp_drain_1", popped[mark + 1], 8'h22);
      checkOutput("bp_drain_2", popped[mark + 2], 8'h33);
    end

    // Reset mid-word discards the partial word
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, acc);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, acc);
    checkOutput("midrst_in_ready", bus0.in_ready, 0);
    checkOutput("midrst_out_valid", bus0.out_valid, 0);
    checkOutput("midrst_out_data", bus0.out_data, 0);
    checkOutput("midrst_out_len", bus0.out_len, 0);
    rst = 1'b0;
    #1;
    checkOutput("midrst_ready_after", bus0.in_ready, 1);
    mark = popped.size();
    sendWord(8'hFF);
    checkOutput("midrst_word_data", bus0.out_data, 8'hFF);
    checkOutput("midrst_word_len", bus0.out_len, 8);
    applyStimulus(1'b0, 1'b0, 1'b0, acc);
    checkOutput("midrst_single_word", popped.size() - mark, 1);

    // Random traffic until 200 words have left the buffer
    start = pops_total;
    for (int c = 0; c < 20000 && (pops_total - start) < 200; c++) begin
      bus0.out_ready = ($urandom_range(0, 99) < 60);
      applyStimulus($urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 99) < 4, acc);
    end
    checkOutput("random_word_count", (pops_total - start) >= 200, 1);
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, acc);
    checkOutput("final_drained", bus0.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
